// File: rtl/sd_read_arbiter.sv
// Round-robin read arbiter: shares one SD block reader among NREQ requesters.
// Define SD_ARB_HIT_EN to answer a repeat of the last block from held sd_data without a new read.
module sd_read_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   req_img_id,
  input  logic [10*NREQ-1:0]   req_block_id,
  output logic [NREQ-1:0]      ack,
  output logic [4095:0]        rd_data,
  output logic                 busy,
  output logic [1:0]           owner,
  output logic                 sd_r,
  output logic [9:0]           sd_img_id,
  output logic [9:0]           sd_block_id,
  input  logic                 sd_done,
  input  logic [4095:0]        sd_data
);

  // state   | meaning
  // IDLE    | waiting for any request, arbitrates when one appears
  // ISSUE   | sd_r high, waiting for block reader completion
  // ACK     | one-cycle ack pulse to the owner
  // RELEASE | waiting for sd_done to fall before re-arbitrating
  typedef enum logic [1:0] {IDLE, ISSUE, ACK, RELEASE} state_t;

  state_t          state_q;
  logic [1:0]      owner_q;
  logic [9:0]      img_q, blk_q;
  logic [NREQ-1:0] ack_q;
  logic            sd_r_q, busy_q;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [9:0]      win_img, win_blk;
  logic [NREQ-1:0] win_oh, own_oh;
  logic            hit;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_img   = '0;
    win_blk   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && req[j] && (j == (int'(owner_q) + k) % NREQ)) begin
          win_found = 1'b1;
          win_idx   = 2'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx == 2'(j)) begin
        win_img = req_img_id[10*j +: 10];
        win_blk = req_block_id[10*j +: 10];
      end
    end
  end

  always_comb begin
    win_oh = '0;
    own_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      win_oh[j] = (win_idx == 2'(j));
      own_oh[j] = (owner_q == 2'(j));
    end
  end

`ifdef SD_ARB_HIT_EN
  logic [9:0] last_img_q, last_blk_q;
  logic       last_valid_q;

  assign hit = last_valid_q && (win_img == last_img_q) && (win_blk == last_blk_q);

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      last_img_q   <= '0;
      last_blk_q   <= '0;
      last_valid_q <= 1'b0;
    end else if (state_q == ACK) begin
      last_img_q   <= img_q;
      last_blk_q   <= blk_q;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      owner_q <= 2'(NREQ - 1);
      img_q   <= '0;
      blk_q   <= '0;
      ack_q   <= '0;
      sd_r_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            owner_q <= win_idx;
            img_q   <= win_img;
            blk_q   <= win_blk;
            busy_q  <= 1'b1;
            if (hit) begin
              state_q <= ACK;
              ack_q   <= win_oh;
            end else begin
              state_q <= ISSUE;
              sd_r_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (sd_done) begin
            state_q <= ACK;
            sd_r_q  <= 1'b0;
            ack_q   <= own_oh;
          end
        end
        ACK: state_q <= RELEASE;
        RELEASE: begin
          if (!sd_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sd_r_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign sd_r        = sd_r_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign sd_img_id   = img_q;
  assign sd_block_id = blk_q;
  assign rd_data     = sd_data;

endmodule

// File: doc/sd_read_arbiter.md
SD_READ_ARBITER -- requirements
Module: sd_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  NREQ  per-requester read request, level, held until own ack.
REQ-005 SHALL have port req_img_id  input  10*NREQ  image id of requester i in bits [10i+9:10i].
REQ-006 SHALL have port req_block_id  input  10*NREQ  block id of requester i in bits [10i+9:10i].
REQ-007 SHALL have port ack  output  NREQ  one-cycle pulse: requester i's block is on rd_data.
REQ-008 SHALL have port rd_data  output  4096  block data, combinational copy of sd_data.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port owner  output  2  index of current/last granted requester.
REQ-011 SHALL have port sd_r  output  1  read strobe to the block reader.
REQ-012 SHALL have ports sd_img_id, sd_block_id  output  10 each  latched ids to the block reader.
REQ-013 SHALL have port sd_done  input  1  block reader completion, held high until sd_r falls.
REQ-014 SHALL have port sd_data  input  4096  block reader data, stable while sd_done high and until next read.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, ACK, RELEASE.
REQ-016 IDLE: if any req bit set, SHALL grant by round-robin starting at (last owner+1) mod NREQ, latch owner and the winner's ids into sd_img_id/sd_block_id, go ISSUE; else stay.
REQ-017 ISSUE: sd_r SHALL be 1; on sd_done=1 go ACK; req changes SHALL be ignored.
REQ-018 ACK: sd_r SHALL be 0, ack[owner] SHALL be 1 for exactly this cycle, record last ids and set last_valid; go RELEASE.
REQ-019 RELEASE: sd_r 0; go IDLE on the first cycle sd_done=0; minimum one cycle in RELEASE.
REQ-020 Grant-to-sd_r latency SHALL be 1 cycle (sd_r high in first ISSUE cycle); sd_done-to-ack latency 1 cycle.
REQ-021 Requester SHALL drop req on the edge after its ack; arbiter SHALL therefore not re-arbitrate earlier than 2 cycles after ack.
REQ-022 sd_img_id/sd_block_id SHALL change only on a grant; at most one ack bit high per cycle.
REQ-023 Round-robin pointer SHALL wrap from NREQ-1 to 0; with a single active requester it SHALL be re-granted every round.
REQ-024 req deasserted while ISSUE SHALL NOT abort the read; ack still pulses.

Reset
REQ-025 On RESET low, asynchronously: state IDLE, sd_r 0, ack 0, busy 0, owner NREQ-1 (so requester 0 wins first), sd_img_id 0, sd_block_id 0, last_valid 0.
REQ-026 Reset during ISSUE SHALL drop sd_r immediately; no ack issued for the aborted read.

Configuration
REQ-027 Macro SD_ARB_HIT_EN: when defined, in IDLE a winner whose ids equal last ids with last_valid=1 SHALL go directly to ACK without asserting sd_r (ack 1 cycle after grant, rd_data = held sd_data); when undefined every grant SHALL issue a read.

Verification
REQ-028 Req0 img 3 block 5 -> sd_img_id=3, sd_block_id=5, sd_r next cycle; sd_done after 20 cycles -> ack=01 one cycle later, rd_data=sd_data.
REQ-029 req=11 simultaneously after reset -> grant order 0,1,0,1 across four rounds with both held.
REQ-030 sd_done held high 5 extra cycles after ack -> stays RELEASE, busy=1, no new sd_r until sd_done low.
REQ-031 RESET low mid-ISSUE -> sd_r=0 same cycle, busy=0, no ack; after release requester 0 granted first.
REQ-032 SD_ARB_HIT_EN defined, req0 repeats img 3 block 5 -> ack 1 cycle after grant, sd_r never high; undefined -> full read issued.
REQ-033 req1 dropped during ISSUE -> read completes, ack=10 still pulses once.
